mux_rr_arbiter: RTL
===================

Name: mux_rr_arbiter

Overview:
- Shares one NUM_INPUTS:1 datapath mux between NUM_INPUTS requesters, each using a valid/ready handshake.
- Picks one requester per cycle by round-robin, drives the shared mux select, and captures the selected word into a registered output stage with its own valid/ready handshake.
- Sits in front of any shared resource, e.g. a single writeback or memory port contended by several pipeline units.

Parameters:
- NUM_INPUTS, 6, number of requesters; legal range 2..16.
- DATA_WIDTH, 8, width of each requester's data word.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req_valid  in  NUM_INPUTS  per-requester valid; bit k belongs to requester k.
- i_data_bus  in  NUM_INPUTS*DATA_WIDTH  packed request data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_req_ready  out  NUM_INPUTS  one-hot-or-zero accept strobe back to the requesters.
- o_valid  out  1  output word valid.
- o_data  out  DATA_WIDTH  registered output word.
- o_src  out  $clog2(NUM_INPUTS)  index of the requester that produced o_data.
- i_ready  in  1  downstream accept.

Behaviour:
- Reset (async assert): o_valid=0, o_data=0, o_src=0, round-robin pointer last_grant=NUM_INPUTS-1, so requester 0 has top priority first.
- o_req_ready is combinational and is 0 while i_rst is high.
- can_load = !o_valid || i_ready.
- Grant:
  - When can_load and |i_req_valid, grant the first requester with valid=1, searching upward from last_grant+1 modulo NUM_INPUTS.
  - o_req_ready has exactly that bit set.
  - Otherwise o_req_ready=0.
- Requester handshake occurs when i_req_valid[k] && o_req_ready[k]. On that edge:
  - o_data <= slice k, taken via the mux with select=k.
  - o_src <= k; o_valid <= 1; last_grant <= k.
- Downstream handshake: o_valid && i_ready. If no new grant occurs in the same cycle, o_valid <= 0; o_data and o_src hold their values.
- Simultaneous downstream accept and new grant: the output register is replaced, so o_valid stays 1. Full throughput is one word per cycle.
- Stall: while o_valid && !i_ready, o_req_ready=0 and o_data/o_src/o_valid hold stable. Requesters must hold valid and data until accepted.
- Latency: 1 cycle from requester handshake to o_valid.
- Two-state view:
  - EMPTY (o_valid=0) -> FULL on a grant.
  - FULL -> EMPTY on i_ready with no request pending.
  - FULL -> FULL on i_ready with a request pending, or on a stall.
- Fairness: a requester that holds valid waits at most NUM_INPUTS-1 grants.
- Pointer wrap: last_grant=NUM_INPUTS-1 searches from 0.
- Reset mid-operation: any word held in the output register is dropped and the pointer returns to its reset value.
- o_src width is $clog2(NUM_INPUTS). Internal indices are never driven out of range.

Optional Feature:
- Macro MUX_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins every time; last_grant is not implemented and starvation is allowed.
- Undefined (default): round-robin as specified above.
- Handshake, latency and stall behaviour are identical in both builds.

Decomposition:
- Package mux_arb_pkg holds:
  - helper function for the select width, idx_w(n)=$clog2(n);
  - reset constant for the pointer;
  - the typedef enum EMPTY/FULL used for state and debug visibility.
- Natural sub-module: rr_pick. It is combinational; given the request vector and last_grant, it returns a one-hot grant plus its index. It contains the MUX_ARB_FIXED_PRIO_EN branch.
- The data path instantiates the existing mux (NUM_INPUTS, DATA_WIDTH) with i_select = the granted index.

Test Plan:
Settings: NUM_INPUTS=6, DATA_WIDTH=8, i_data_bus={AA,BB,CC,DD,EE,FF}, so requester 0 carries FF and requester 5 carries AA.
- Reset check: hold i_rst=1 with i_req_valid=3F. Expect o_valid=0, o_data=00, o_src=0, o_req_ready=00. Release reset, then in the next cycle expect o_req_ready=01, and o_data=FF with o_src=0 one cycle later.
- Round-robin rotation: i_req_valid=3F held, i_ready=1 held. Expect o_src sequence 0,1,2,3,4,5,0 and o_data FF,EE,DD,CC,BB,AA,FF, with o_valid continuously 1.
- Sparse requests with wrap: i_req_valid=21, i_ready=1, starting from last_grant=5. Expect grants alternating 0,5,0,5 with o_data alternating FF/AA.
- Back-pressure: after a grant to requester 2, hold i_ready=0 for 3 cycles. Expect o_data=DD, o_src=2, o_valid=1 held stable and o_req_ready=00. On i_ready=1, expect the next grant in that same cycle.
- Async reset while FULL: assert i_rst mid-cycle. Expect o_valid=0 immediately, without waiting for a clock edge. After release, the first grant goes to the lowest active index.
- Fixed-priority build (MUX_ARB_FIXED_PRIO_EN): i_req_valid=3F, i_ready=1. Expect o_src=0 and o_data=FF on every cycle.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Optional build macro MUX_ARB_FIXED_PRIO_EN is consumed by rr_pick and mux_rr_arbiter.
package mux_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Pointer reset value: the last requester, so the first search starts at 0.
  function automatic int last_grant_rst(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/mux.sv
// Plain NUM_INPUTS:1 word mux; an out-of-range select yields zero.
module mux
  import mux_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic [idx_w(NUM_INPUTS)-1:0]     i_select,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data_bus,
  output logic [DATA_WIDTH-1:0]            o_data
);

  always_comb begin
    o_data = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (int'(i_select) == k) o_data = i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational requester picker: round-robin after i_last_grant, or fixed
// lowest-index priority when MUX_ARB_FIXED_PRIO_EN is defined.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 6
) (
  input  logic [NUM_INPUTS-1:0]        i_req,
  input  logic [idx_w(NUM_INPUTS)-1:0] i_last_grant,
  output logic [NUM_INPUTS-1:0]        o_grant,
  output logic [idx_w(NUM_INPUTS)-1:0] o_grant_idx
);

  localparam int SEL_W = idx_w(NUM_INPUTS);

`ifdef MUX_ARB_FIXED_PRIO_EN
  logic found;

  always_comb begin
    found       = 1'b0;
    o_grant     = '0;
    o_grant_idx = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (!found && i_req[k]) begin
        found       = 1'b1;
        o_grant[k]  = 1'b1;
        o_grant_idx = SEL_W'(k);
      end
    end
  end

  logic unused_last_grant;
  assign unused_last_grant = ^i_last_grant;
`else
  logic found;
  int   k;

  // Visit every index once, starting just after the previous winner.
  always_comb begin
    found       = 1'b0;
    o_grant     = '0;
    o_grant_idx = '0;
    k           = 0;
    for (int n = 1; n <= NUM_INPUTS; n++) begin
      k = (int'(i_last_grant) + n) % NUM_INPUTS;
      if (!found && i_req[k]) begin
        found       = 1'b1;
        o_grant[k]  = 1'b1;
        o_grant_idx = SEL_W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one data mux, with a one-word registered output stage.
// MUX_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_INPUTS-1:0]            i_req_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data_bus,
  output logic [NUM_INPUTS-1:0]            o_req_ready,
  output logic                             o_valid,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic [$clog2(NUM_INPUTS)-1:0]    o_src,
  input  logic                             i_ready,
  output logic                             o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. Upstream ready is one-hot-or-zero; o_valid only drops after
  // i_ready, and o_data/o_src are stable while o_valid && !i_ready.

  localparam int SEL_W = idx_w(NUM_INPUTS);

  arb_state_t             state;
  logic [SEL_W-1:0]       last_grant;
  logic [NUM_INPUTS-1:0]  grant;
  logic [SEL_W-1:0]       grant_idx;
  logic [DATA_WIDTH-1:0]  mux_data;
  logic                   can_load;
  logic                   load;

  rr_pick #(
    .NUM_INPUTS(NUM_INPUTS)
  ) u_pick (
    .i_req       (i_req_valid),
    .i_last_grant(last_grant),
    .o_grant     (grant),
    .o_grant_idx (grant_idx)
  );

  mux #(
    .NUM_INPUTS(NUM_INPUTS),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .i_select  (grant_idx),
    .i_data_bus(i_data_bus),
    .o_data    (mux_data)
  );

  assign can_load    = (state == EMPTY) || i_ready;
  assign o_req_ready = (can_load && !i_rst) ? grant : '0;
  assign load        = |o_req_ready;
  assign o_valid     = (state == FULL);
  assign o_dbg_state = state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= EMPTY;
      o_data <= '0;
      o_src  <= '0;
    end else if (load) begin
      state  <= FULL;
      o_data <= mux_data;
      o_src  <= grant_idx;
    end else if (i_ready) begin
      state  <= EMPTY;
    end
  end

`ifdef MUX_ARB_FIXED_PRIO_EN
  assign last_grant = '0;
`else
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     last_grant <= SEL_W'(last_grant_rst(NUM_INPUTS));
    else if (load) last_grant <= grant_idx;
  end
`endif

endmodule
